// File: rtl/bvinv_pkg.sv
// Shared types and the closed-form invertibility condition for the
// unsigned-multiply / ugt inverse-search family.
package bvinv_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // x*s >u t is solvable iff t <u ((-s) | s), all in W-bit arithmetic
  function automatic logic bvinv_ic_ugt_mul(input logic [W_DEF-1:0] s,
                                            input logic [W_DEF-1:0] t);
    logic [W_DEF-1:0] m;
    m = (-s) | s;
    return t < m;
  endfunction

endpackage

// File: rtl/bvmul_ugt_inv_search_if.sv
// Query/response bundle for the inverse-search solver; slave = solver side.
interface bvmul_ugt_inv_search_if #(parameter int W = 4) ();

  logic         req_valid_i;
  logic         req_ready_o;
  logic [W-1:0] s_i;
  logic [W-1:0] t_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic         found_o;
  logic [W-1:0] x_o;
  logic         ic_o;
  logic         ic_mismatch_o;
  logic [W:0]   sol_count_o;

  modport slave (
    input  req_valid_i, s_i, t_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, found_o, x_o, ic_o, ic_mismatch_o, sol_count_o
  );

  modport master (
    output req_valid_i, s_i, t_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, found_o, x_o, ic_o, ic_mismatch_o, sol_count_o
  );

endinterface

// File: rtl/bvmul_ugt_eval.sv
// Single-candidate evaluator: hit = (x*s mod 2^W) >u t. Purely combinational.
module bvmul_ugt_eval #(
  parameter int W = bvinv_pkg::W_DEF
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] t_i,
  output logic         hit_o
);

  logic [W-1:0] prod;

  assign prod  = x_i * s_i;  // truncation to W bits is the modular product
  assign hit_o = prod > t_i;

endmodule

// File: rtl/bvmul_ugt_inv_search.sv
// Sequential sweep solver for x*s >u t with IC cross-check.
// BVINV_SOL_COUNT_EN: full sweep every query and count all solutions.
module bvmul_ugt_inv_search
  import bvinv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  bvmul_ugt_inv_search_if.slave bus
);

  state_e       state_q;
  logic [W-1:0] s_q, t_q, x_cnt_q, x_q;
  logic         found_q, req_ready_q, rsp_valid_q, ic_q, ic_mism_q;

  logic         hit, found_d, last, search_end, ic_d;
  logic [W-1:0] x_cnt_d;

  bvmul_ugt_eval #(.W(W)) u_eval (
    .x_i   (x_cnt_q),
    .s_i   (s_q),
    .t_i   (t_q),
    .hit_o (hit)
  );

  assign found_d = found_q | hit;
  assign last    = (x_cnt_q == {W{1'b1}});
  assign x_cnt_d = x_cnt_q + W'(1);
  assign ic_d    = bvinv_ic_ugt_mul(s_q, t_q);

`ifdef BVINV_SOL_COUNT_EN
  logic [W:0] cnt_q;

  assign search_end = last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       cnt_q <= '0;
    else if (state_q == IDLE && bus.req_valid_i)   cnt_q <= '0;
    else if (state_q == SEARCH && hit)             cnt_q <= cnt_q + (W+1)'(1);
  end

  assign bus.sol_count_o = cnt_q;
`else
  assign search_end      = hit | last;
  assign bus.sol_count_o = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      t_q         <= '0;
      x_cnt_q     <= '0;
      x_q         <= '0;
      found_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      ic_q        <= 1'b0;
      ic_mism_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid_i && req_ready_q) begin
          s_q         <= bus.s_i;
          t_q         <= bus.t_i;
          x_cnt_q     <= '0;
          x_q         <= '0;
          found_q     <= 1'b0;
          req_ready_q <= 1'b0;
          state_q     <= SEARCH;
        end
        SEARCH: begin
          if (hit && !found_q) begin
            x_q     <= x_cnt_q;
            found_q <= 1'b1;
          end
          // terminal check wins over increment so the counter never wraps
          if (search_end) begin
            ic_q        <= ic_d;
            ic_mism_q   <= ic_d ^ found_d;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            x_cnt_q <= x_cnt_d;
          end
        end
        DONE: if (bus.rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.found_o       = found_q;
  assign bus.x_o           = x_q;
  assign bus.ic_o          = ic_q;
  assign bus.ic_mismatch_o = ic_mism_q;

endmodule

// File: tb/tb_bvmul_ugt_inv_search.sv
// Directed + exhaustive scoreboard bench for bvmul_ugt_inv_search.
module tb_bvmul_ugt_inv_search;

  localparam int W = 4;
`ifdef BVINV_SOL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bvmul_ugt_inv_search_if #(.W(W)) bus ();
  bvmul_ugt_inv_search #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       found;
    logic [3:0] x;
    logic       ic;
    logic [4:0] cnt;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic       last_found, last_ic;
  logic [3:0] last_x;
  logic [4:0] last_cnt;
  int         last_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] s, input logic [3:0] t);
    exp_t       e;
    logic [3:0] p, m;
    e.found = 1'b0; e.x = '0; e.cnt = '0;
    for (int x = 0; x < 16; x++) begin
      p = 4'(x * int'(s));
      if (p > t) begin
        e.cnt++;
        if (!e.found) begin e.found = 1'b1; e.x = 4'(x); end
      end
    end
    m    = 4'(16 - int'(s)) | s;
    e.ic = t < m;
    if (CNT_EN) e.lat = 16;
    else begin
      e.lat = e.found ? int'(e.x) + 1 : 16;
      e.cnt = '0;
    end
    return e;
  endfunction

  task automatic do_query(input logic [3:0] s, input logic [3:0] t, input int hold);
    exp_t       g;
    int         n;
    logic [3:0] xh;
    sb.push_back(model(s, t));
    bus.s_i = s; bus.t_i = t; bus.req_valid_i = 1'b1;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("req_ready", 32'(bus.req_ready_o), 1);
    @(posedge clk); #1;               // accept edge
    bus.req_valid_i = 1'b0;
    chk("req_ready_busy", 32'(bus.req_ready_o), 0);
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    g = sb.pop_front();
    chk("latency",  n, g.lat);
    chk("found",    32'(bus.found_o), 32'(g.found));
    chk("x",        32'(bus.x_o), 32'(g.x));
    chk("ic",       32'(bus.ic_o), 32'(g.ic));
    chk("ic_mism",  32'(bus.ic_mismatch_o), 0);
    chk("count",    32'(bus.sol_count_o), 32'(g.cnt));
    last_found = bus.found_o; last_x = bus.x_o; last_ic = bus.ic_o;
    last_cnt = bus.sol_count_o; last_lat = n;
    xh = bus.x_o;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid_i = i[0];
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.rsp_valid_o), 1);
      chk("bp_x",     32'(bus.x_o), 32'(xh));
      chk("bp_ready", 32'(bus.req_ready_o), 0);
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    chk("rsp_drop",   32'(bus.rsp_valid_o), 0);
    chk("ready_back", 32'(bus.req_ready_o), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 1);
    chk({tag, "_valid"}, 32'(bus.rsp_valid_o), 0);
    chk({tag, "_found"}, 32'(bus.found_o), 0);
    chk({tag, "_x"},     32'(bus.x_o), 0);
    chk({tag, "_ic"},    32'(bus.ic_o), 0);
    chk({tag, "_mism"},  32'(bus.ic_mismatch_o), 0);
    chk({tag, "_cnt"},   32'(bus.sol_count_o), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
    bus.s_i = '0; bus.t_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_query(4'd3, 4'd5, 0);
    chk("d35_x", 32'(last_x), 2);
    chk("d35_found", 32'(last_found), 1);
    chk("d35_ic", 32'(last_ic), 1);
    chk("d35_lat", last_lat, CNT_EN ? 16 : 3);
    chk("d35_cnt", 32'(last_cnt), CNT_EN ? 10 : 0);

    do_query(4'd2, 4'd13, 0);
    chk("d213_x", 32'(last_x), 7);
    chk("d213_lat", last_lat, CNT_EN ? 16 : 8);
    chk("d213_cnt", 32'(last_cnt), CNT_EN ? 2 : 0);

    do_query(4'd1, 4'd15, 0);
    chk("d115_found", 32'(last_found), 0);
    chk("d115_x", 32'(last_x), 0);
    chk("d115_ic", 32'(last_ic), 0);
    chk("d115_lat", last_lat, 16);

    do_query(4'd0, 4'd0, 0);
    chk("d00_found", 32'(last_found), 0);
    chk("d00_lat", last_lat, 16);
    chk("d00_cnt", 32'(last_cnt), 0);

    do_query(4'd3, 4'd5, 10);
    chk("bp_x_final", 32'(last_x), 2);

    // abort an s=1,t=15 sweep a few edges in
    bus.s_i = 4'd1; bus.t_i = 4'd15; bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 32'(bus.rsp_valid_o), 0);
    end
    do_query(4'd3, 4'd5, 0);
    chk("post_abort_x", 32'(last_x), 2);

    for (int s = 0; s < 16; s++)
      for (int t = 0; t < 16; t++)
        do_query(4'(s), 4'(t), 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
